// File: rtl/step0_1_if.sv
// Beat-stream interface for the BF II stage (step0_1): input and output lanes with their qualifiers.
interface step0_1_if #(
  parameter int LANES = 16,
  parameter int IN_W  = 10,
  parameter int OUT_W = 11
);
  logic                    din_valid;
  logic signed [IN_W-1:0]  din_re  [LANES];
  logic signed [IN_W-1:0]  din_im  [LANES];
  logic                    dout_valid;
  logic signed [OUT_W-1:0] dout_re [LANES];
  logic signed [OUT_W-1:0] dout_im [LANES];
  logic [4:0]              dout_idx;

  modport master (
    output din_valid, din_re, din_im,
    input  dout_valid, dout_re, dout_im, dout_idx
  );

  modport slave (
    input  din_valid, din_re, din_im,
    output dout_valid, dout_re, dout_im, dout_idx
  );
endinterface

// File: rtl/step0_1.sv
// Second radix-2 butterfly stage (pair distance 8 beats) of the 512-point streaming FFT, single-delay-feedback.
// Optional output saturation to the input range is enabled by defining STEP0_1_SAT_EN.
module step0_1 #(
  parameter int LANES = 16,
  parameter int IN_W  = 10,
  parameter int OUT_W = 11,
  parameter int HALF  = 8
) (
  input logic      clk,
  input logic      rst,
  step0_1_if.slave bus
);

`ifdef STEP0_1_SAT_EN
  localparam logic signed [OUT_W-1:0] SAT_MAX = OUT_W'((1 << (IN_W-1)) - 1);
  localparam logic signed [OUT_W-1:0] SAT_MIN = OUT_W'(-(1 << (IN_W-1)));
`endif

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [OUT_W-1:0] x);
`ifdef STEP0_1_SAT_EN
    if (x > SAT_MAX) return SAT_MAX;
    if (x < SAT_MIN) return SAT_MIN;
`endif
    return x;
  endfunction

  logic [4:0]              in_cnt;
  logic [2:0]              drain_cnt;
  logic                    drain_act;
  logic                    drain_g;
  logic signed [OUT_W-1:0] mem_re [HALF][LANES];
  logic signed [OUT_W-1:0] mem_im [HALF][LANES];

  logic                    vld_p1;
  logic [4:0]              dout_idx_p1;
  logic signed [OUT_W-1:0] dout_re_p1 [LANES];
  logic signed [OUT_W-1:0] dout_im_p1 [LANES];

  logic [2:0]              wr_k;
  logic                    pair_beat;
  logic signed [OUT_W-1:0] ext_re [LANES];
  logic signed [OUT_W-1:0] ext_im [LANES];
  logic signed [OUT_W-1:0] sum_re [LANES];
  logic signed [OUT_W-1:0] sum_im [LANES];
  logic signed [OUT_W-1:0] dif_re [LANES];
  logic signed [OUT_W-1:0] dif_im [LANES];

  assign wr_k      = in_cnt[2:0];
  assign pair_beat = bus.din_valid & in_cnt[3];

  // ---- p0: butterfly of buffered partner (earlier beat) with incoming beat
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      ext_re[j] = {{(OUT_W-IN_W){bus.din_re[j][IN_W-1]}}, bus.din_re[j]};
      ext_im[j] = {{(OUT_W-IN_W){bus.din_im[j][IN_W-1]}}, bus.din_im[j]};
      sum_re[j] = mem_re[wr_k][j] + ext_re[j];
      sum_im[j] = mem_im[wr_k][j] + ext_im[j];
      dif_re[j] = mem_re[wr_k][j] - ext_re[j];
      dif_im[j] = mem_im[wr_k][j] - ext_im[j];
    end
  end

  // Fill writes the raw beat, pair writes the difference back for the drain.
  // A drain read of the same slot sees the old value since the write is registered.
  always_ff @(posedge clk) begin
    if (bus.din_valid) begin
      for (int j = 0; j < LANES; j++) begin
        mem_re[wr_k][j] <= in_cnt[3] ? dif_re[j] : ext_re[j];
        mem_im[wr_k][j] <= in_cnt[3] ? dif_im[j] : ext_im[j];
      end
    end
  end

  // ---- p1: registered output, sums on pair beats, differences while draining
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_cnt      <= '0;
      drain_cnt   <= '0;
      drain_act   <= 1'b0;
      drain_g     <= 1'b0;
      vld_p1      <= 1'b0;
      dout_idx_p1 <= '0;
      for (int j = 0; j < LANES; j++) begin
        dout_re_p1[j] <= '0;
        dout_im_p1[j] <= '0;
      end
    end else begin
      vld_p1 <= 1'b0;
      if (bus.din_valid) begin
        in_cnt <= in_cnt + 5'd1;
        if (in_cnt[3:0] == 4'hF) begin
          drain_act <= 1'b1;
          drain_cnt <= '0;
          drain_g   <= in_cnt[4];
        end
      end
      if (pair_beat) begin
        vld_p1      <= 1'b1;
        dout_idx_p1 <= {in_cnt[4], 1'b0, wr_k};
        for (int j = 0; j < LANES; j++) begin
          dout_re_p1[j] <= sat_out(sum_re[j]);
          dout_im_p1[j] <= sat_out(sum_im[j]);
        end
      end
      if (drain_act) begin
        vld_p1      <= 1'b1;
        dout_idx_p1 <= {drain_g, 1'b1, drain_cnt};
        for (int j = 0; j < LANES; j++) begin
          dout_re_p1[j] <= sat_out(mem_re[drain_cnt][j]);
          dout_im_p1[j] <= sat_out(mem_im[drain_cnt][j]);
        end
        drain_cnt <= drain_cnt + 3'd1;
        if (drain_cnt == 3'd7) drain_act <= 1'b0;
      end
    end
  end

  assign bus.dout_valid = vld_p1;
  assign bus.dout_idx   = dout_idx_p1;
  assign bus.dout_re    = dout_re_p1;
  assign bus.dout_im    = dout_im_p1;

endmodule

// File: tb/tb_step0_1.sv
// Scoreboard bench for step0_1: a per-group butterfly model queues expected beats, a negedge monitor checks them.
module tb_step0_1;
  localparam int LANES = 16;
  localparam int IN_W  = 10;
  localparam int OUT_W = 11;
  localparam int LW    = LANES * OUT_W;

  typedef struct packed {
    logic [LW-1:0] re;
    logic [LW-1:0] im;
    logic [4:0]    idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  step0_1_if #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  step0_1 #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .HALF(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   run      = 0;
  int   last_run = 0;
  int   first_cyc = -1;
  logic prev_v   = 1'b0;
  exp_t sb[$];

  logic [4:0]              bcnt;
  logic signed [IN_W-1:0]  cur_re [LANES];
  logic signed [IN_W-1:0]  cur_im [LANES];
  logic signed [OUT_W-1:0] fill_re [8][LANES];
  logic signed [OUT_W-1:0] fill_im [8][LANES];
  logic signed [OUT_W-1:0] diff_re [8][LANES];
  logic signed [OUT_W-1:0] diff_im [8][LANES];

  function automatic logic signed [OUT_W-1:0] tsat(input logic signed [OUT_W-1:0] v);
`ifdef STEP0_1_SAT_EN
    if (v > 11'sd511)  return 11'sd511;
    if (v < -11'sd512) return -11'sd512;
`endif
    return v;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: every valid beat must match the head of the scoreboard.
  initial begin
    exp_t          e;
    logic [LW-1:0] ar, ai;
    forever begin
      @(negedge clk);
      if (bus.dout_valid === 1'b1) begin
        if (!prev_v) first_cyc = cyc;
        run++;
        for (int j = 0; j < LANES; j++) begin
          ar[j*OUT_W +: OUT_W] = bus.dout_re[j];
          ai[j*OUT_W +: OUT_W] = bus.dout_im[j];
        end
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_out idx=%0d re=%h (no beat expected)", bus.dout_idx, ar);
        end else begin
          e = sb.pop_front();
          if ({ar, ai, bus.dout_idx} !== {e.re, e.im, e.idx})
            $display("FAIL out_beat idx got %0d want %0d re got %h want %h im got %h want %h",
                     bus.dout_idx, e.idx, ar, e.re, ai, e.im);
          else n_pass++;
        end
      end else begin
        if (run > 0) last_run = run;
        run = 0;
      end
      prev_v = (bus.dout_valid === 1'b1);
    end
  end

  task automatic model_reset();
    bcnt = '0;
    sb.delete();
  endtask

  task automatic model_accept();
    logic [2:0]              k;
    logic                    g;
    logic signed [OUT_W-1:0] br, bi;
    exp_t                    e;
    k = bcnt[2:0];
    g = bcnt[4];
    if (!bcnt[3]) begin
      for (int j = 0; j < LANES; j++) begin
        fill_re[k][j] = cur_re[j];
        fill_im[k][j] = cur_im[j];
      end
    end else begin
      for (int j = 0; j < LANES; j++) begin
        br = cur_re[j];
        bi = cur_im[j];
        e.re[j*OUT_W +: OUT_W] = tsat(fill_re[k][j] + br);
        e.im[j*OUT_W +: OUT_W] = tsat(fill_im[k][j] + bi);
        diff_re[k][j] = fill_re[k][j] - br;
        diff_im[k][j] = fill_im[k][j] - bi;
      end
      e.idx = {g, 1'b0, k};
      sb.push_back(e);
      if (k == 3'd7) begin
        for (int d = 0; d < 8; d++) begin
          for (int j = 0; j < LANES; j++) begin
            e.re[j*OUT_W +: OUT_W] = tsat(diff_re[d][j]);
            e.im[j*OUT_W +: OUT_W] = tsat(diff_im[d][j]);
          end
          e.idx = {g, 1'b1, 3'(d)};
          sb.push_back(e);
        end
      end
    end
    bcnt = bcnt + 5'd1;
  endtask

  task automatic send_beat();
    for (int j = 0; j < LANES; j++) begin
      bus.din_re[j] = cur_re[j];
      bus.din_im[j] = cur_im[j];
    end
    bus.din_valid = 1'b1;
    model_accept();
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.din_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ramp(input int b);
    for (int j = 0; j < LANES; j++) begin
      cur_re[j] = IN_W'(b);
      cur_im[j] = IN_W'(-b);
    end
  endtask

  task automatic set_rand();
    for (int j = 0; j < LANES; j++) begin
      cur_re[j] = IN_W'($urandom_range(0, 1023));
      cur_im[j] = IN_W'($urandom_range(0, 1023));
    end
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    idle(4);
    n_checks++;
    if (sb.size() != 0) $display("FAIL %s_timeout pending got %0d want 0", name, sb.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.din_valid = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      bus.din_re[j] = '0;
      bus.din_im[j] = '0;
    end
    model_reset();
    idle(3);
    n_checks++;
    if (bus.dout_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.dout_valid);
    else n_pass++;
    n_checks++;
    if (bus.dout_idx !== 5'd0) $display("FAIL reset_idx got %0d want 0", bus.dout_idx);
    else n_pass++;
    for (int j = 0; j < LANES; j++) begin
      n_checks++;
      if (bus.dout_re[j] !== '0 || bus.dout_im[j] !== '0)
        $display("FAIL reset_data lane %0d got %0d/%0d want 0/0", j, bus.dout_re[j], bus.dout_im[j]);
      else n_pass++;
    end
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_reset_mid_drain();
    for (int b = 0; b < 16; b++) begin
      set_rand();
      send_beat();
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    n_checks++;
    if (bus.dout_valid !== 1'b0) $display("FAIL middrain_valid got %b want 0", bus.dout_valid);
    else n_pass++;
    n_checks++;
    if (bus.dout_idx !== 5'd0 || bus.dout_re[3] !== '0 || bus.dout_im[15] !== '0)
      $display("FAIL middrain_zero idx/re3/im15 got %0d/%0d/%0d want 0/0/0",
               bus.dout_idx, bus.dout_re[3], bus.dout_im[15]);
    else n_pass++;
    rst = 1'b1;
    idle(12);
  endtask

  task automatic test_back_to_back();
    int start;
    first_cyc = -1;
    start = cyc;
    for (int b = 0; b < 32; b++) begin
      set_ramp(b);
      send_beat();
    end
    for (int b = 0; b < 32; b++) begin
      set_rand();
      send_beat();
    end
    wait_drain("b2b");
    n_checks++;
    if (first_cyc - start !== 9) $display("FAIL b2b_latency got %0d want 9", first_cyc - start);
    else n_pass++;
    n_checks++;
    if (last_run !== 64) $display("FAIL b2b_continuous got %0d want 64", last_run);
    else n_pass++;
  endtask

  task automatic test_single_group();
    for (int b = 0; b < 16; b++) begin
      set_rand();
      send_beat();
    end
    wait_drain("single");
    n_checks++;
    if (last_run !== 16) $display("FAIL single_run got %0d want 16", last_run);
    else n_pass++;
    idle(16);
  endtask

  task automatic test_gaps();
    for (int b = 0; b < 32; b++) begin
      set_ramp(b);
      send_beat();
      idle(1);
    end
    wait_drain("gaps");
    n_checks++;
    if (last_run !== 9) $display("FAIL gaps_drain_run got %0d want 9", last_run);
    else n_pass++;
  endtask

  task automatic test_extremes();
    for (int b = 0; b < 32; b++) begin
      for (int j = 0; j < LANES; j++) begin
        if (b < 16) begin
          cur_re[j] = (b < 8) ? 10'sd511 : ((j % 2 == 0) ? 10'sd511 : -10'sd512);
          cur_im[j] = (b < 8) ? 10'sd511 : ((j % 2 == 1) ? 10'sd511 : -10'sd512);
        end else begin
          cur_re[j] = (b < 24) ? -10'sd512 : ((j % 2 == 0) ? -10'sd512 : 10'sd511);
          cur_im[j] = (b < 24) ? -10'sd512 : ((j % 2 == 1) ? -10'sd512 : 10'sd511);
        end
      end
      send_beat();
    end
    wait_drain("extremes");
  endtask

  initial begin
    test_reset();
    test_reset_mid_drain();
    test_back_to_back();
    test_single_group();
    test_gaps();
    test_extremes();
    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
